// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: nibble-serial W-bit add/subtract sequencer feeding a single
// 4-bit ripple slice, with start/ready/done handshake and registered results.

module adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c_s;

  // ripple carry chain across the four bits of the slice
  always_comb begin
    c_s    = 5'b0_0000;
    sum    = 4'b0000;
    c_s[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c_s[4];
endmodule

module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   ready,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES) + 1;
  localparam int SH_W  = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [W-1:0]     opa_r, opa_s;
  logic [W-1:0]     opb_r, opb_s;
  logic             carry_r, carry_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [W-1:0]     result_r, result_s;
  logic             cout_r, cout_s;
  logic             ovf_r, ovf_s;
  logic             done_r, done_s;
  logic             ready_r, ready_s;

  logic [SH_W-1:0]  shamt_s;
  logic [3:0]       nib_a_s, nib_b_s, slice_sum_s;
  logic             slice_cout_s;

  // bit offset of the current nibble; slice inputs are don't-care outside RUN
  assign shamt_s = {idx_r, 2'b00};
  assign nib_a_s = 4'(opa_r >> shamt_s);
  assign nib_b_s = 4'(opb_r >> shamt_s);

  adder_4b adder_4b_ins (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    opa_s    = opa_r;
    opb_s    = opb_r;
    carry_s  = carry_r;
    idx_s    = idx_r;
    result_s = result_r;
    cout_s   = cout_r;
    ovf_s    = ovf_r;
    done_s   = 1'b0;
    ready_s  = ready_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          opa_s    = a;
          opb_s    = sub ? ~b : b;
          carry_s  = sub;
          idx_s    = {IDX_W{1'b0}};
          result_s = {W{1'b0}};
          cout_s   = 1'b0;
          ovf_s    = 1'b0;
          ready_s  = 1'b0;
          state_s  = RUN;
        end else begin
          ready_s  = 1'b1;
          state_s  = IDLE;
        end
      end
      RUN: begin
        result_s = (result_r & ~(W'(4'hF) << shamt_s)) | (W'(slice_sum_s) << shamt_s);
        carry_s  = slice_cout_s;
        idx_s    = idx_r + IDX_W'(1);
        if (idx_r == LAST_IDX) begin
          // opb already holds ~b for subtraction, so one rule covers both
          cout_s  = slice_cout_s;
          ovf_s   = (opa_r[W-1] == opb_r[W-1]) && (slice_sum_s[3] != opa_r[W-1]);
          done_s  = 1'b1;
          ready_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        ready_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      opa_r    <= {W{1'b0}};
      opb_r    <= {W{1'b0}};
      carry_r  <= 1'b0;
      idx_r    <= {IDX_W{1'b0}};
      result_r <= {W{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      opa_r    <= opa_s;
      opb_r    <= opb_s;
      carry_r  <= carry_s;
      idx_r    <= idx_s;
      result_r <= result_s;
      cout_r   <= cout_s;
      ovf_r    <= ovf_s;
      done_r   <= done_s;
      ready_r  <= ready_s;
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: directed handshake/boundary cases on NIBBLES=4 and
// random add/sub regression on NIBBLES=1, 4, 16 against an arithmetic model.

module tb_adder_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, sub0, ready0, done0, cout0, ovf0;
  logic [3:0]  a0, b0, res0;
  logic        start1, sub1, ready1, done1, cout1, ovf1;
  logic [15:0] a1, b1, res1;
  logic        start2, sub2, ready2, done2, cout2, ovf2;
  logic [63:0] a2, b2, res2;

  int total = 0;
  int bad   = 0;

  adder_seq_ctrl #(.NIBBLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0), .a(a0), .b(b0),
    .ready(ready0), .done(done0), .result(res0), .cout(cout0), .ovf(ovf0));
  adder_seq_ctrl #(.NIBBLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .ready(ready1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1));
  adder_seq_ctrl #(.NIBBLES(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int nib(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 4 : 16);
  endfunction

  function automatic logic [63:0] o_res(input int u);
    if (u == 0) return {60'd0, res0};
    else if (u == 1) return {48'd0, res1};
    else return res2;
  endfunction

  function automatic logic o_ready(input int u);
    return (u == 0) ? ready0 : ((u == 1) ? ready1 : ready2);
  endfunction

  function automatic logic o_done(input int u);
    return (u == 0) ? done0 : ((u == 1) ? done1 : done2);
  endfunction

  function automatic logic o_cout(input int u);
    return (u == 0) ? cout0 : ((u == 1) ? cout1 : cout2);
  endfunction

  function automatic logic o_ovf(input int u);
    return (u == 0) ? ovf0 : ((u == 1) ? ovf1 : ovf2);
  endfunction

  task automatic drive(input int u, input logic st, input logic s,
                       input logic [63:0] a, input logic [63:0] b);
    case (u)
      0: begin start0 = st; sub0 = s; a0 = a[3:0];  b0 = b[3:0];  end
      1: begin start1 = st; sub1 = s; a1 = a[15:0]; b1 = b[15:0]; end
      default: begin start2 = st; sub2 = s; a2 = a; b2 = b; end
    endcase
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain unsigned and signed arithmetic on the W-bit operands
  function automatic void model(input int w, input logic s, input logic [63:0] ai,
                                input logic [63:0] bi, output logic [63:0] r,
                                output logic c, output logic o);
    logic [63:0] m, a, b;
    logic [64:0] us;
    logic signed [65:0] sa, sb, sr, lim;
    m = wmask(w);
    a = ai & m;
    b = bi & m;
    if (s) begin
      r = (a - b) & m;
      c = (a >= b);
    end else begin
      us = {1'b0, a} + {1'b0, b};
      r  = us[63:0] & m;
      c  = us[w];
    end
    lim = $signed(66'd1 << (w - 1));
    sa  = $signed({2'b00, a});
    sb  = $signed({2'b00, b});
    if (a[w-1]) sa = sa - (lim <<< 1);
    if (b[w-1]) sb = sb - (lim <<< 1);
    sr = s ? (sa - sb) : (sa + sb);
    o  = (sr >= lim) || (sr < -lim);
  endfunction

  // Called #1 after an accepting edge; counts edges until done, bounded.
  task automatic wait_done(input int u, input string tag);
    int n = 0;
    while (o_done(u) !== 1'b1 && n < 200) begin
      chk({tag, "_busy"}, {63'd0, o_ready(u)}, 64'd0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(nib(u)));
  endtask

  task automatic do_op(input int u, input logic s, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    logic [63:0] er;
    logic ec, eo;
    model(4 * nib(u), s, a, b, er, ec, eo);
    chk({tag, "_rdy"}, {63'd0, o_ready(u)}, 64'd1);
    drive(u, 1'b1, s, a, b);
    @(posedge clk); #1;
    drive(u, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
    chk({tag, "_clr"}, {o_res(u)[61:0], o_cout(u), o_ovf(u)}, 64'd0);
    wait_done(u, tag);
    chk({tag, "_res"}, o_res(u), er);
    chk({tag, "_cout"}, {63'd0, o_cout(u)}, {63'd0, ec});
    chk({tag, "_ovf"}, {63'd0, o_ovf(u)}, {63'd0, eo});
    chk({tag, "_rdydone"}, {63'd0, o_ready(u)}, 64'd1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {63'd0, o_done(u)}, 64'd0);
    chk({tag, "_hold"}, o_res(u), er);
  endtask

  task automatic rand_operand(input int w, output logic [63:0] v);
    logic [63:0] m;
    m = wmask(w);
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = m;
      2: v = m >> 1;
      3: v = (m >> 1) + 64'd1;
      default: v = {$urandom, $urandom} & m;
    endcase
  endtask

  initial begin
    logic [63:0] ra, rb;
    int n;
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int u = 0; u < 3; u++) begin
      chk("rst_ready", {63'd0, o_ready(u)}, 64'd1);
      chk("rst_done", {63'd0, o_done(u)}, 64'd0);
      chk("rst_res", o_res(u), 64'd0);
      chk("rst_cout", {63'd0, o_cout(u)}, 64'd0);
      chk("rst_ovf", {63'd0, o_ovf(u)}, 64'd0);
    end

    do_op(1, 1'b0, 64'h1234, 64'h0FFF, "add_1234");
    do_op(1, 1'b0, 64'hFFFF, 64'h0001, "add_wrap");
    do_op(1, 1'b0, 64'h7FFF, 64'h0001, "add_ovf");
    do_op(1, 1'b1, 64'h0005, 64'h0007, "sub_borrow");
    do_op(1, 1'b1, 64'h8000, 64'h0001, "sub_ovf");
    chk("lit_sub_ovf_res", o_res(1), 64'h7FFF);

    // start held high through RUN with changing operands, then back-to-back
    drive(1, 1'b1, 1'b0, 64'h1, 64'h2);
    @(posedge clk); #1;
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin
      drive(1, 1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      @(posedge clk); #1;
      n++;
    end
    chk("hold_lat", 64'(n), 64'd4);
    chk("hold_res", o_res(1), 64'h0003);
    chk("hold_cout", {63'd0, cout1}, 64'd0);
    drive(1, 1'b1, 1'b0, 64'h10, 64'h20);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
    chk("b2b_done", {63'd0, done1}, 64'd0);
    chk("b2b_ready", {63'd0, ready1}, 64'd0);
    chk("b2b_clr", o_res(1), 64'd0);
    wait_done(1, "b2b");
    chk("b2b_res", o_res(1), 64'h0030);
    @(posedge clk); #1;

    // reset in the second RUN cycle aborts without a done pulse
    drive(1, 1'b1, 1'b0, 64'hAAAA, 64'h5555);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 64'h0, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_ready", {63'd0, ready1}, 64'd1);
    chk("mid_rst_res", o_res(1), 64'd0);
    chk("mid_rst_cout", {63'd0, cout1}, 64'd0);
    chk("mid_rst_ovf", {63'd0, ovf1}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_nodone", {63'd0, done1}, 64'd0);
      @(posedge clk); #1;
    end
    do_op(1, 1'b0, 64'hAAAA, 64'h5555, "after_rst");
    chk("lit_after_rst", o_res(1), 64'hFFFF);

    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 25; k++) begin
        rand_operand(4 * nib(u), ra);
        rand_operand(4 * nib(u), rb);
        do_op(u, 1'($urandom_range(0, 1)), ra, rb, $sformatf("rnd_u%0d_%0d", u, k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
